// File: rtl/layer1_pkg.sv
// Shared types and frame-size defaults for the layer 1 datapath.
// Used by the window generator, tree adder and weight ROM.
package layer1_pkg;

   localparam int L1_DATA_W = 16;
   localparam int L1_IMG_W  = 28;
   localparam int L1_IMG_H  = 28;

   typedef logic signed [15:0] pix_t;
   typedef pix_t [8:0] win_t;

   // Counter width for a range of n values, never below one bit.
   function automatic int cnt_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/layer1_line_buf.sv
// One row of pixel storage: combinational read, clocked write.
// A read and write to the same address in one cycle returns the old entry.
module layer1_line_buf
   import layer1_pkg::*;
#(
   parameter int DATA_W = L1_DATA_W,
   parameter int DEPTH  = L1_IMG_W,
   parameter int AW     = cnt_w(L1_IMG_W)
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [AW-1:0]            addr,
   input  logic signed [DATA_W-1:0] wdata,
   output logic signed [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   // Row storage is deliberately not reset; stale rows are masked upstream.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

endmodule

// File: rtl/layer1_window_gen.sv
// 3x3 valid-only sliding-window generator over a raster pixel stream.
// Optional counters: define LAYER1_WIN_PERF_EN for stall_cnt / win_cnt.
module layer1_window_gen
   import layer1_pkg::*;
#(
   parameter int DATA_W = L1_DATA_W,
   parameter int IMG_W  = L1_IMG_W,
   parameter int IMG_H  = L1_IMG_H
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_sof,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic signed [DATA_W-1:0] win_p1,
   output logic signed [DATA_W-1:0] win_p2,
   output logic signed [DATA_W-1:0] win_p3,
   output logic signed [DATA_W-1:0] win_p4,
   output logic signed [DATA_W-1:0] win_p5,
   output logic signed [DATA_W-1:0] win_p6,
   output logic signed [DATA_W-1:0] win_p7,
   output logic signed [DATA_W-1:0] win_p8,
   output logic signed [DATA_W-1:0] win_p9
`ifdef LAYER1_WIN_PERF_EN
   ,
   output logic [31:0]              stall_cnt,
   output logic [31:0]              win_cnt
`endif
);

   localparam int CW = cnt_w(IMG_W);
   localparam int RW = cnt_w(IMG_H);

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   logic [CW-1:0] col;
   logic [CW-1:0] cur_col;
   logic [RW-1:0] row;
   logic [RW-1:0] cur_row;

   logic accept;
   logic xfer;
   logic win_done;
   logic frame_end;

   logic signed [DATA_W-1:0] top;
   logic signed [DATA_W-1:0] mid;
   logic signed [DATA_W-1:0] w [3][3];

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid && out_ready;

   // A start-of-frame pixel lands at (0,0) whatever the counters say.
   assign cur_col  = in_sof ? '0 : col;
   assign cur_row  = in_sof ? '0 : row;

   assign win_done  = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
   assign frame_end = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

   layer1_line_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W),
      .AW     (CW)
   ) u_lb0 (
      .clk   (clk),
      .we    (accept),
      .addr  (cur_col),
      .wdata (mid),
      .rdata (top)
   );

   layer1_line_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W),
      .AW     (CW)
   ) u_lb1 (
      .clk   (clk),
      .we    (accept),
      .addr  (cur_col),
      .wdata (in_data),
      .rdata (mid)
   );

   // Raster position of the next pixel, wrapping per row and per frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (cur_col == COL_LAST) begin
            col <= '0;
            row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
         end else begin
            col <= cur_col + 1'b1;
            row <= cur_row;
         end
      end
   end

   // Shift the window left and bring in the new column {top, mid, bot}.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               w[r][c] <= '0;
            end
         end
      end else if (accept) begin
         for (int r = 0; r < 3; r++) begin
            w[r][0] <= w[r][1];
            w[r][1] <= w[r][2];
         end
         w[0][2] <= top;
         w[1][2] <= mid;
         w[2][2] <= in_data;
      end
   end

   // Flag a window once the accepted pixel closes a full 3x3 block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (accept) begin
         out_valid <= win_done;
         out_last  <= win_done && frame_end;
      end else if (xfer) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

   assign win_p1 = w[0][0];
   assign win_p2 = w[0][1];
   assign win_p3 = w[0][2];
   assign win_p4 = w[1][0];
   assign win_p5 = w[1][1];
   assign win_p6 = w[1][2];
   assign win_p7 = w[2][0];
   assign win_p8 = w[2][1];
   assign win_p9 = w[2][2];

`ifdef LAYER1_WIN_PERF_EN
   // Saturating count of cycles a window waits on downstream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   // Saturating count of windows handed off since the last frame start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_cnt <= '0;
      end else if (accept && in_sof) begin
         win_cnt <= '0;
      end else if (xfer && (win_cnt != '1)) begin
         win_cnt <= win_cnt + 1'b1;
      end
   end
`endif

endmodule
